// File: rtl/an_codes_pkg.sv
// Shared definitions for the AN-code encoder/decoder family: default code
// parameters, the encoder state encoding and the codeword width check.
package an_codes_pkg;

  localparam int AN_A    = 13;
  localparam int AN_N_W  = 8;
  localparam int AN_CW_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } an_state_e;

  // True when the largest codeword A*(2^N_W-1) fits in CW_W bits.
  function automatic bit an_fits(input int a, input int n_w, input int cw_w);
    longint max_code;
    longint limit;
    max_code = longint'(a) * ((longint'(1) << n_w) - longint'(1));
    limit    = longint'(1) << cw_w;
    return max_code < limit;
  endfunction

endpackage

// File: rtl/an_shift_add_mul.sv
// Serial shift-add multiplier: product = A * din, one multiplier bit per
// cycle, exactly N_W iterations after start; done pulses for one cycle.
module an_shift_add_mul
  import an_codes_pkg::*;
#(
  parameter int A    = AN_A,
  parameter int N_W  = AN_N_W,
  parameter int CW_W = AN_CW_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N_W-1:0]  din,
  output logic            done,
  output logic [CW_W-1:0] product
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N_W - 1);
  localparam logic [CW_W-1:0]  MCAND_INIT = CW_W'(A);

  logic [N_W-1:0]  sreg_q,  sreg_d;
  logic [CW_W-1:0] acc_q,   acc_d;
  logic [CW_W-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic            run_q,   run_d;
  logic            done_q,  done_d;

  always_comb begin
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (start) begin
      sreg_d  = din;
      acc_d   = '0;
      mcand_d = MCAND_INIT;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      // Truncation is safe: the width check guarantees no carry out.
      if (sreg_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      sreg_d  = sreg_q >> 1;
      mcand_d = mcand_q << 1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q  <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/an_encoder_serial.sv
// AN-code encoder: out_code = A*in_data via a serial multiplier, with
// valid/ready on both sides. Optional bit-flip injection: AN_ERR_INJECT_EN.
module an_encoder_serial
  import an_codes_pkg::*;
#(
  parameter int A    = AN_A,
  parameter int N_W  = AN_N_W,
  parameter int CW_W = AN_CW_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_W-1:0]          in_data,
`ifdef AN_ERR_INJECT_EN
  input  logic                    inj_en,
  input  logic [$clog2(CW_W)-1:0] inj_bit,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW_W-1:0]         out_code,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MUL  = MUL;
  localparam logic [1:0] S_DONE = DONE;

  if (!an_fits(A, N_W, CW_W)) begin : g_bad_width
    $error("an_encoder_serial: A*(2^N_W-1) does not fit in CW_W bits");
  end
  if ((A < 3) || ((A % 2) == 0)) begin : g_bad_a
    $error("an_encoder_serial: A must be odd and at least 3");
  end

  logic [1:0]      state_q, state_d;
  logic [CW_W-1:0] out_code_q, out_code_d;
  logic            accept;
  logic            mul_done;
  logic [CW_W-1:0] mul_product;
  logic [CW_W-1:0] flip_mask;

  assign accept = (state_q == S_IDLE) && in_valid;

  an_shift_add_mul #(
    .A    (A),
    .N_W  (N_W),
    .CW_W (CW_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .din     (in_data),
    .done    (mul_done),
    .product (mul_product)
  );

`ifdef AN_ERR_INJECT_EN
  localparam int INJ_W = $clog2(CW_W);

  logic             inj_en_q,  inj_en_d;
  logic [INJ_W-1:0] inj_bit_q, inj_bit_d;

  // Out-of-range bit positions select no flip rather than wrapping.
  function automatic logic [CW_W-1:0] inj_mask(input logic en,
                                               input logic [INJ_W-1:0] pos);
    if (en && (int'(pos) < CW_W)) begin
      return CW_W'(1) << pos;
    end
    return '0;
  endfunction

  always_comb begin
    inj_en_d  = inj_en_q;
    inj_bit_d = inj_bit_q;
    if (accept) begin
      inj_en_d  = inj_en;
      inj_bit_d = inj_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_en_q  <= 1'b0;
      inj_bit_q <= '0;
    end else begin
      inj_en_q  <= inj_en_d;
      inj_bit_q <= inj_bit_d;
    end
  end

  assign flip_mask = inj_mask(inj_en_q, inj_bit_q);
`else
  assign flip_mask = '0;
`endif

  always_comb begin
    state_d    = state_q;
    out_code_d = out_code_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d    = S_DONE;
          out_code_d = mul_product ^ flip_mask;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      out_code_q <= '0;
    end else begin
      state_q    <= state_d;
      out_code_q <= out_code_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DONE);
  assign out_code  = out_code_q;

endmodule

// File: tb/tb_an_encoder_serial.sv
// Directed self-checking bench for an_encoder_serial (A=13, N_W=8, CW_W=12);
// injection cases are compiled in when AN_ERR_INJECT_EN is defined.
module tb_an_encoder_serial;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_code;
  logic        busy;
`ifdef AN_ERR_INJECT_EN
  logic        inj_en;
  logic [3:0]  inj_bit;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  an_encoder_serial #(
    .A    (13),
    .N_W  (8),
    .CW_W (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef AN_ERR_INJECT_EN
    .inj_en    (inj_en),
    .inj_bit   (inj_bit),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one word, check latency, optionally stall the output, check the code.
  task automatic encode(input logic [7:0] d, input int stall, input logic [31:0] exp_code,
                        input string tag, output int acc_cyc);
    int guard;
    int lat;
    out_ready = (stall == 0);
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, "_ready_timeout"}, 32'(guard < 40), 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = ~d;
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_in_ready_low"}, 32'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, 9);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_valid"}, 32'(out_valid), 1);
      chk({tag, "_stall_code"}, 32'(out_code), exp_code);
      chk({tag, "_stall_in_ready"}, 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk({tag, "_code"}, 32'(out_code), exp_code);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 32'(out_valid), 0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 1);
  endtask

  initial begin
    int t0;
    int t1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef AN_ERR_INJECT_EN
    inj_en    = 1'b0;
    inj_bit   = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_code", 32'(out_code), 0);
    chk("reset_busy", 32'(busy), 0);

    encode(8'd252, 0, 32'd3276, "w252", t0);

    encode(8'd0, 0, 32'd0, "w0", t0);
    encode(8'd255, 0, 32'd3315, "w255", t1);
    chk("b2b_spacing_ge10", 32'((t1 - t0) >= 10), 1);

    encode(8'd100, 5, 32'd1300, "w100_stall", t0);

    // Reset three cycles into the multiply discards the word.
    in_valid = 1'b1;
    in_data  = 8'd252;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_code", 32'(out_code), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_late_valid", 32'(out_valid), 0);
    encode(8'd1, 0, 32'd13, "w1_after_rst", t0);

`ifdef AN_ERR_INJECT_EN
    inj_en = 1'b1;
    inj_bit = 4'd0;
    encode(8'd252, 0, 32'd3277, "inj_bit0", t0);
    inj_bit = 4'd9;
    encode(8'd252, 0, 32'd3788, "inj_bit9", t0);
    inj_bit = 4'd4;
    encode(8'd252, 0, 32'd3292, "inj_bit4", t0);
    inj_bit = 4'd15;
    encode(8'd252, 0, 32'd3276, "inj_bit15", t0);
    inj_en = 1'b0;
    inj_bit = 4'd0;
    encode(8'd252, 0, 32'd3276, "inj_off", t0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
